password_enroller: RTL
======================

# password_enroller

Collects a new multi-digit password for the logged-in player from the password switches and writes it into the shared password store, the same store that the access controller reads during login. It is the writer side of the password-store interface. It sits beside the access controller, driven by the same shaped button pulses, and issues one held write request per successful enrollment to the store arbiter. An optional confirm pass forces the player to re-enter the password before it is committed.

## Interface
Parameters:
- DIGITS, 4: password length in digits
- DIGIT_W, 4: bits per digit (switch width)
- ID_W, 5: player id width (store address)
- TIMEOUT_CYCLES, 50_000_000: idle cycles allowed between digit entries before abort

Ports:
- clk  in  1  system clock
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- enroll_start  in  1  one-cycle pulse that begins enrollment
- player_id  in  ID_W  target player; captured on enroll_start
- digit_in  in  DIGIT_W  password switches
- digit_pulse  in  1  one-cycle pulse from the shaped password-enter button
- cancel_pulse  in  1  one-cycle pulse from the shaped log-out button
- wr_req  out  1  write request to the store
- wr_addr  out  ID_W  store address (captured player id)
- wr_data  out  DIGITS*DIGIT_W  password; first digit entered is the most significant nibble
- wr_ack  in  1  store accepted the write (one cycle)
- busy  out  1  high in any state other than IDLE
- digit_count  out  3  digits collected in the current pass (LED feedback)
- done_pulse  out  1  one cycle: password committed
- fail_pulse  out  1  one cycle: mismatch, timeout or cancel

## Operation
- States: IDLE, ENTER, CONFIRM, WRITE.
- IDLE: on enroll_start, capture player_id, clear the digit register and the count, load the timeout counter, and go to ENTER.
- ENTER: each digit_pulse shifts digit_in into the first-pass register and increments digit_count. When count reaches DIGITS, go to CONFIRM (or to WRITE when confirm is compiled out). In either case, reset the count to 0 and reload the timeout.
- CONFIRM: collect DIGITS digits into a second register. On the last digit, compare the two registers. If they are equal, go to WRITE. If they differ, raise fail_pulse and go to IDLE.
- WRITE: wr_req is held high, with wr_addr and wr_data stable, until wr_ack is sampled high. The next cycle: done_pulse rises, wr_req drops, and the state goes to IDLE.
- Timeout: in ENTER and CONFIRM, the counter decrements each cycle and reloads on every digit_pulse. On reaching 0, raise fail_pulse and go to IDLE.
- cancel_pulse in ENTER or CONFIRM: raise fail_pulse and go to IDLE. In WRITE it is ignored, so an in-flight write always completes.
- enroll_start outside IDLE is ignored.
- A digit_pulse and a cancel_pulse in the same cycle: cancel wins and the digit is discarded.
- wr_ack outside WRITE is ignored.
- The store is never written on a fail path.

## Timing
- Reset values (asynchronous): state IDLE; wr_req 0, wr_addr 0, wr_data 0, busy 0, digit_count 0, done_pulse 0, fail_pulse 0; the timeout counter is loaded.
- All outputs are registered.
- The final digit_pulse moves the state on the following edge. wr_req is high one cycle after the final digit (confirm off) or after the final confirm digit (confirm on).
- If wr_ack arrives in the first wr_req cycle, done_pulse follows 1 cycle later, for a total of 2 cycles from the last digit to done.
- If rst asserts mid-WRITE, wr_req drops immediately and no done_pulse is issued.
- digit_count wraps to 0 at each pass boundary and never shows DIGITS.

## Configuration
- ENROLL_CONFIRM_EN defined: the CONFIRM state and the second digit register are present, and a mismatch produces fail_pulse.
- ENROLL_CONFIRM_EN not defined: ENTER goes directly to WRITE, the second register and the comparator are absent, and fail_pulse can fire only on timeout or cancel.

## Structure
- The shared game package holds the state enumeration, DIGITS, DIGIT_W, ID_W, the derived PW_W = DIGITS*DIGIT_W, and TIMEOUT_CYCLES.
- One sub-module, pswd_digit_collector, contains the shift register, the digit counter and a full flag. It is instantiated once per pass: once in the first-pass configuration, twice when confirm is enabled.

## Test plan
- Confirm off: enroll_start with id 5'd7, then digits 3,1,4,1 -> one wr_req with wr_addr 7 and wr_data 16'h3141; wr_ack -> done_pulse on the next cycle, and busy low after that.
- Confirm on: digits 9,0,0,2 entered twice -> wr_data 16'h9002 is written. Entering 9,0,0,2 then 9,0,0,3 -> fail_pulse, no wr_req, state back in IDLE.
- After 2 digits, no input for TIMEOUT_CYCLES (set to 20 in the bench) -> fail_pulse on exactly the 20th idle cycle, and digit_count returns to 0.
- cancel_pulse together with digit_pulse at the third digit -> fail_pulse, and the digit is not counted. cancel_pulse while wr_req is high -> write completes and done_pulse still fires.
- wr_ack held low for 5 cycles -> wr_req, wr_addr and wr_data stay constant for all 5 cycles, then done_pulse follows.
- rst low for 1 cycle mid-WRITE -> wr_req is 0 immediately, no done_pulse, and a fresh enroll_start works.

Source files
------------

// File: rtl/password_enroller_pkg.sv
// Shared game package: password-store geometry, enrollment timeout and the
// enrollment state encoding.
package password_enroller_pkg;

  localparam int unsigned DIGITS         = 4;
  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned ID_W           = 5;
  localparam int unsigned PW_W           = DIGITS * DIGIT_W;
  localparam int unsigned TIMEOUT_CYCLES = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_WRITE   = 2'd3
  } enroll_state_e;

endpackage

// File: rtl/pswd_digit_collector.sv
// One password pass: shifts digits in MSB-first, counts them and flags the
// last slot. Exposes next-state values so the owner can act on the final digit.
module pswd_digit_collector #(
  parameter int unsigned DIGITS  = password_enroller_pkg::DIGITS,
  parameter int unsigned DIGIT_W = password_enroller_pkg::DIGIT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      shift,
  input  logic [DIGIT_W-1:0]        digit_in,
  output logic [DIGITS*DIGIT_W-1:0] value_nxt_c,
  output logic [2:0]                count_nxt_c,
  output logic                      full_c
);

  localparam int unsigned VAL_W = DIGITS * DIGIT_W;

  logic [VAL_W-1:0] value_q, value_d;
  logic [2:0]       count_q, count_d;

  // The count wraps on the last digit so a completed pass never reads DIGITS.
  assign full_c = (count_q == 3'(DIGITS - 1));

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear) begin
      value_d = '0;
      count_d = '0;
    end else if (shift) begin
      value_d = (value_q << DIGIT_W) | VAL_W'(digit_in);
      count_d = full_c ? 3'd0 : count_q + 3'd1;
    end
  end

  assign value_nxt_c = value_d;
  assign count_nxt_c = count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/password_enroller.sv
// Password-store writer: collects a new password for a player and issues one
// held write per enrollment. ENROLL_CONFIRM_EN adds a re-entry confirm pass.
module password_enroller #(
  parameter int unsigned DIGITS         = password_enroller_pkg::DIGITS,
  parameter int unsigned DIGIT_W        = password_enroller_pkg::DIGIT_W,
  parameter int unsigned ID_W           = password_enroller_pkg::ID_W,
  parameter int unsigned TIMEOUT_CYCLES = password_enroller_pkg::TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enroll_start,
  input  logic [ID_W-1:0]           player_id,
  input  logic [DIGIT_W-1:0]        digit_in,
  input  logic                      digit_pulse,
  input  logic                      cancel_pulse,
  output logic                      wr_req,
  output logic [ID_W-1:0]           wr_addr,
  output logic [DIGITS*DIGIT_W-1:0] wr_data,
  input  logic                      wr_ack,
  output logic                      busy,
  output logic [2:0]                digit_count,
  output logic                      done_pulse,
  output logic                      fail_pulse
);
  import password_enroller_pkg::*;

  localparam int unsigned DATA_W = DIGITS * DIGIT_W;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  enroll_state_e     state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              wr_req_q, wr_req_d;
  logic [ID_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic [2:0]        digit_count_q, digit_count_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  logic              start_c, abort_c, dig_c, fail_c, done_c;
  logic              sh1_c, c1_full_c;
  logic [DATA_W-1:0] c1_val_c;
  logic [2:0]        c1_cnt_c;

  assign start_c = (state_q == ST_IDLE) && enroll_start;
  // Cancel beats a same-cycle digit; timeout only fires on a digit-free cycle.
  assign abort_c = cancel_pulse || (!digit_pulse && (tmo_q == TMO_W'(1)));
  assign sh1_c   = (state_q == ST_ENTER) && digit_pulse && !cancel_pulse;

  pswd_digit_collector #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_pass1 (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_c),
    .shift       (sh1_c),
    .digit_in    (digit_in),
    .value_nxt_c (c1_val_c),
    .count_nxt_c (c1_cnt_c),
    .full_c      (c1_full_c)
  );

`ifdef ENROLL_CONFIRM_EN
  logic              sh2_c, c2_full_c, match_c;
  logic [DATA_W-1:0] c2_val_c;
  logic [2:0]        c2_cnt_c;

  assign sh2_c = (state_q == ST_CONFIRM) && digit_pulse && !cancel_pulse;

  pswd_digit_collector #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_pass2 (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_c),
    .shift       (sh2_c),
    .digit_in    (digit_in),
    .value_nxt_c (c2_val_c),
    .count_nxt_c (c2_cnt_c),
    .full_c      (c2_full_c)
  );

  // The first pass holds during CONFIRM, so its next value is its stored value.
  assign match_c = (c2_val_c == c1_val_c);
  assign dig_c   = sh1_c | sh2_c;
`else
  assign dig_c   = sh1_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      tmo_q         <= TMO_LOAD;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      digit_count_q <= 3'd0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      wr_req_q      <= wr_req_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      digit_count_q <= digit_count_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fail_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        if (abort_c) begin
          fail_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (sh1_c && c1_full_c) begin
`ifdef ENROLL_CONFIRM_EN
          state_d = ST_CONFIRM;
`else
          state_d = ST_WRITE;
`endif
        end
      end
      ST_CONFIRM: begin
`ifdef ENROLL_CONFIRM_EN
        if (abort_c) begin
          fail_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (sh2_c && c2_full_c) begin
          if (match_c) begin
            state_d = ST_WRITE;
          end else begin
            fail_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_WRITE: begin
        // Cancel is deliberately ignored here so an in-flight write completes.
        if (wr_ack) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_d         = tmo_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    digit_count_d = 3'd0;
    wr_req_d      = (state_d == ST_WRITE);
    busy_d        = (state_d != ST_IDLE);
    done_d        = done_c;
    fail_d        = fail_c;
    if (start_c) wr_addr_d = player_id;
    if ((state_q != ST_WRITE) && (state_d == ST_WRITE)) wr_data_d = c1_val_c;
    if ((state_q == ST_IDLE) || dig_c) begin
      tmo_d = TMO_LOAD;
    end else if ((state_q == ST_ENTER) || (state_q == ST_CONFIRM)) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
    case (state_d)
      ST_ENTER:   digit_count_d = c1_cnt_c;
`ifdef ENROLL_CONFIRM_EN
      ST_CONFIRM: digit_count_d = c2_cnt_c;
`endif
      default:    digit_count_d = 3'd0;
    endcase
  end

  assign wr_req      = wr_req_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign digit_count = digit_count_q;
  assign done_pulse  = done_q;
  assign fail_pulse  = fail_q;

endmodule
